// File: rtl/multicycle_seq_pkg.sv
// Shared types and PC-unit opcodes for the multi-cycle instruction sequencer.
package multicycle_seq_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RGRD,
    S_ALU,
    S_MEM,
    S_RGWR,
    S_UPDATE,
    S_HALT,
    S_ERR
  } state_e;

  localparam logic [1:0] PCOP_RST  = 2'b11;
  localparam logic [1:0] PCOP_BR   = 2'b10;
  localparam logic [1:0] PCOP_INC  = 2'b01;
  localparam logic [1:0] PCOP_HOLD = 2'b00;

endpackage

// File: rtl/multicycle_seq_timeout.sv
// Handshake wait counter: cleared on entry to a wait state, expires on the
// TIMEOUT-th waiting cycle that still has no ack.
module seq_timeout #(
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 8
) (
  input  logic I_clk,
  input  logic I_reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  assign expired = en && (cnt_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer for the 16-bit core: one-hot stage enables,
// req/ack waits with timeout, PC-unit opcode, retire counter and halt/run control.
//   state  | meaning
//   RST    | PC reset, one cycle after reset release
//   IDLE   | waiting for run
//   FETCH  | instruction memory request, waiting for ack
//   DECODE | latch memreq/regwe from decoder
//   RGRD   | register read
//   ALU    | execute, latch branch flag
//   MEM    | data memory request, waiting for ack
//   RGWR   | register writeback
//   UPDATE | PC update and retire
//   HALT   | stopped between instructions
//   ERR    | handshake timeout, left only by reset
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_run,
  input  logic             I_halt,
  input  logic             I_fetch_ack,
  input  logic             I_mem_ack,
  input  logic             I_memreq,
  input  logic             I_regwe,
  input  logic             I_shldbranch,
  output logic             o_enfetch,
  output logic             o_endec,
  output logic             o_enrgrd,
  output logic             o_enalu,
  output logic             o_enmem,
  output logic             o_enrgwr,
  output logic             o_fetch_req,
  output logic             o_mem_req,
  output logic [1:0]       o_pcop,
  output logic             o_busy,
  output logic             o_err,
  output logic [CNT_W-1:0] o_retired
);

  state_e           state_q, state_d;
  logic             memreq_q, memreq_d;
  logic             regwe_q, regwe_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             tmo_clr, tmo_en, tmo_expired;

  assign tmo_en = ((state_q == S_FETCH) && !I_fetch_ack) ||
                  ((state_q == S_MEM) && !I_mem_ack);
  assign tmo_clr = (state_d != state_q) &&
                   ((state_d == S_FETCH) || (state_d == S_MEM));

  seq_timeout #(
    .TIMEOUT(TIMEOUT),
    .TMO_W  (TMO_W)
  ) u_timeout (
    .I_clk  (I_clk),
    .I_reset(I_reset),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    memreq_d  = memreq_q;
    regwe_d   = regwe_q;
    br_d      = br_q;
    retired_d = retired_q;
    unique case (state_q)
      S_RST:    state_d = S_IDLE;
      S_IDLE:   if (I_run) state_d = S_FETCH;
      S_FETCH: begin
        // an ack on the final allowed cycle beats the timeout
        if (I_fetch_ack)      state_d = S_DECODE;
        else if (tmo_expired) state_d = S_ERR;
      end
      S_DECODE: begin
        memreq_d = I_memreq;
        regwe_d  = I_regwe;
        state_d  = S_RGRD;
      end
      S_RGRD:   state_d = S_ALU;
      S_ALU: begin
        br_d = I_shldbranch;
        if (memreq_q)     state_d = S_MEM;
        else if (regwe_q) state_d = S_RGWR;
        else              state_d = S_UPDATE;
      end
      S_MEM: begin
        if (I_mem_ack)        state_d = regwe_q ? S_RGWR : S_UPDATE;
        else if (tmo_expired) state_d = S_ERR;
      end
      S_RGWR:   state_d = S_UPDATE;
      S_UPDATE: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = I_halt ? S_HALT : S_FETCH;
      end
      S_HALT:   if (I_run && !I_halt) state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  always_comb begin
    o_enfetch   = 1'b0;
    o_endec     = 1'b0;
    o_enrgrd    = 1'b0;
    o_enalu     = 1'b0;
    o_enmem     = 1'b0;
    o_enrgwr    = 1'b0;
    o_fetch_req = 1'b0;
    o_mem_req   = 1'b0;
    o_pcop      = PCOP_HOLD;
    o_busy      = 1'b0;
    o_err       = 1'b0;
    unique case (state_q)
      S_RST:    o_pcop = PCOP_RST;
      S_FETCH:  begin o_enfetch = 1'b1; o_fetch_req = 1'b1; o_busy = 1'b1; end
      S_DECODE: begin o_endec = 1'b1; o_busy = 1'b1; end
      S_RGRD:   begin o_enrgrd = 1'b1; o_busy = 1'b1; end
      S_ALU:    begin o_enalu = 1'b1; o_busy = 1'b1; end
      S_MEM:    begin o_enmem = 1'b1; o_mem_req = 1'b1; o_busy = 1'b1; end
      S_RGWR:   begin o_enrgwr = 1'b1; o_busy = 1'b1; end
      S_UPDATE: begin o_pcop = br_q ? PCOP_BR : PCOP_INC; o_busy = 1'b1; end
      S_ERR:    o_err = 1'b1;
      default:  o_pcop = PCOP_HOLD;
    endcase
  end

  assign o_retired = retired_q;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q   <= S_RST;
      memreq_q  <= 1'b0;
      regwe_q   <= 1'b0;
      br_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      memreq_q  <= memreq_d;
      regwe_q   <= regwe_d;
      br_q      <= br_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: doc/multicycle_seq.md
# multicycle_seq

Parametrised successor to the CPU control unit: a multi-cycle instruction sequencer for the 16-bit core. It drives one-hot stage enables for fetch, decode, register read, ALU, memory and register write. Memory stages use req/ack handshakes with a timeout, and stages the decoded instruction does not need are skipped. It also drives the PC-unit opcode, counts retired instructions, and supports halt/run control.

## Interface
- TIMEOUT, 64: max cycles a req may wait for ack before error (≥2)
- TMO_W, 8: timeout counter width (2^TMO_W > TIMEOUT)
- CNT_W, 32: retired-instruction counter width
- I_clk  in  1  clock, rising edge
- I_reset  in  1  asynchronous, active-high reset
- I_run  in  1  start/resume request
- I_halt  in  1  stop after current instruction
- I_fetch_ack  in  1  instruction memory data valid
- I_mem_ack  in  1  data memory access complete
- I_memreq  in  1  decoder: instruction accesses data memory (sampled in DECODE)
- I_regwe  in  1  decoder: instruction writes a register (sampled in DECODE)
- I_shldbranch  in  1  ALU branch-taken flag (sampled in ALU)
- o_enfetch, o_endec, o_enrgrd, o_enalu, o_enmem, o_enrgwr  out  1 each  stage enables, at most one high
- o_fetch_req  out  1  instruction memory request
- o_mem_req  out  1  data memory request
- o_pcop  out  2  PC-unit op: 11 reset, 10 branch load, 01 increment, 00 hold
- o_busy  out  1  instruction in flight (FETCH..UPDATE)
- o_err  out  1  sticky handshake-timeout error
- o_retired  out  CNT_W  retired-instruction count

## Operation
- States: RST, IDLE, FETCH, DECODE, RGRD, ALU, MEM, RGWR, UPDATE, HALT, ERR. Outputs are Moore, decoded from the state register.
- RST: o_pcop=11. Always goes to IDLE next.
- IDLE: o_pcop=00. Goes to FETCH when I_run=1.
- FETCH: o_enfetch=o_fetch_req=1.
  - On I_fetch_ack: go to DECODE.
  - Timeout: go to ERR.
- DECODE: o_endec=1. Latch memreq_q←I_memreq and regwe_q←I_regwe. Go to RGRD.
- RGRD: o_enrgrd=1. Go to ALU.
- ALU: o_enalu=1. Latch br_q←I_shldbranch. Next state:
  - MEM if memreq_q;
  - else RGWR if regwe_q;
  - else UPDATE.
- MEM: o_enmem=o_mem_req=1.
  - On I_mem_ack: go to RGWR if regwe_q, else UPDATE.
  - Timeout: go to ERR.
- RGWR: o_enrgwr=1. Go to UPDATE.
- UPDATE: o_pcop = br_q ? 10 : 01. o_retired increments and wraps at 2^CNT_W.
  - I_halt=1: go to HALT.
  - Else: go to FETCH.
- HALT: o_pcop=00. Goes to FETCH when I_run=1 and I_halt=0.
- ERR: all enables and reqs 0, o_pcop=00, o_err=1. Left only by reset.
- Timeout counter:
  - Cleared on every entry to FETCH or MEM.
  - Increments each waiting cycle without ack.
  - Reaching TIMEOUT-1 with no ack in that cycle causes the move to ERR, i.e. TIMEOUT request cycles in total.
  - Ack in the same cycle the count hits TIMEOUT-1 wins (no error).
- Simultaneous events:
  - I_run and I_halt are ignored outside IDLE, UPDATE and HALT.
  - I_halt=1 in UPDATE still retires and updates the PC.
  - Acks arriving outside their wait state are ignored.

## Timing
- Reset asserted (async): state=RST immediately. Every enable, req, o_busy and o_err is 0. o_pcop=11. o_retired=0. memreq_q/regwe_q/br_q=0.
- After reset release: one cycle in RST, then IDLE.
- Latency with ack in the first request cycle:
  - ALU-only instruction: 5 cycles (FETCH, DECODE, RGRD, ALU, UPDATE).
  - ALU + writeback: 6 cycles.
  - Load with writeback: 7 cycles.
  - Each ack-wait cycle adds 1.
- o_busy=1 in FETCH through UPDATE inclusive.
- o_retired changes on the clock edge leaving UPDATE.
- Req stays high until the ack cycle, including that cycle. It drops on the next edge.
- Reset mid-instruction aborts with no retire and no PC update other than 11.

## Structure
- Package multicycle_seq_pkg: state enum, PCOP_RST/PCOP_BR/PCOP_INC/PCOP_HOLD constants.
- Sub-module seq_timeout: clear/enable/expire counter, parametrised by TIMEOUT and TMO_W. One instance is shared by FETCH and MEM.
- Top: state register, latched flags, output decode, retire counter.

## Test plan
- Reset held 3 cycles, then released with I_run=1 and ack tied high, I_memreq=I_regwe=0 → o_pcop=11 during reset and for 1 cycle after release. Then FETCH..UPDATE sequence with o_pcop=01 every 5th cycle and o_retired=1,2,3.
- I_memreq=1, I_regwe=1, I_mem_ack delayed 3 cycles → o_mem_req high exactly 4 cycles, 10-cycle instruction, one-hot enables throughout.
- I_shldbranch=1 in ALU → o_pcop=10 in UPDATE. Next instruction with I_shldbranch=0 → 01.
- I_fetch_ack never asserted, TIMEOUT=4 → ERR after 4 FETCH cycles, o_err=1 sticky, o_retired unchanged. Ack on the 4th cycle instead → no error.
- I_halt=1 at UPDATE → HALT, o_busy=0. I_run pulsed while I_halt=1 → stays in HALT. I_halt=0, I_run=1 → FETCH next cycle.
- Async reset asserted mid-MEM (between edges) → outputs go to reset values immediately, o_retired=0. CNT_W=4 run of 17 instructions → o_retired wraps to 1.
